reg_lock_access_agent: RTL and testbench

- Single-port requester FSM that sits directly upstream of one port of a locked physical register.
- Accepts one read or write command at a time from an issue/operand stage, then drives that port's req_read/req_write/req_issue_id/wdata.
- Waits for grant, which may arrive in the same cycle as the request. Captures read data, or commits write data, on the grant edge.
- Pulses release_lock, then returns a response with an optional timeout error.

---
 rtl/reg_lock_access_agent.sv | 120 ++++++++++++
 tb/tb_reg_lock_access_agent.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_lock_access_agent.sv
// Single-port requester for one port of a locked physical register: takes one
// command, requests the lock, captures or commits on grant, releases and responds.
module reg_lock_access_agent #(
   parameter int unsigned ID_WIDTH = 4,
   parameter int unsigned TIMEOUT  = 15,
   parameter int unsigned WAIT_W   = $clog2(TIMEOUT + 2)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_write,
   input  logic [ID_WIDTH-1:0] cmd_id,
   input  logic [31:0]         cmd_wdata,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [31:0]         rsp_rdata,
   output logic                rsp_err,
   output logic [WAIT_W-1:0]   rsp_wait,
   output logic                req_read,
   output logic                req_write,
   output logic [ID_WIDTH-1:0] req_issue_id,
   output logic                release_lock,
   output logic [31:0]         wdata,
   input  logic                grant,
   input  logic [31:0]         rdata
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      RELEASE = 2'd2,
      RESPOND = 2'd3
   } state_t;

   localparam logic        TMO_EN = (TIMEOUT != 0);
   localparam int unsigned LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
   localparam logic [WAIT_W-1:0] LAST    = LAST_I[WAIT_W-1:0];
   localparam logic [WAIT_W-1:0] TMO_VAL = TIMEOUT[WAIT_W-1:0];

   state_t              state, state_d;
   logic                lat_write;
   logic [ID_WIDTH-1:0] lat_id;
   logic [31:0]         lat_wdata;
   logic [WAIT_W-1:0]   cnt;
   logic [31:0]         rdata_q;
   logic                err_q;
   logic [WAIT_W-1:0]   wait_q;
   logic                expire;

   assign expire = TMO_EN && (cnt == LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_d;
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (cmd_valid)     state_d = ACQUIRE;
         ACQUIRE: if (grant)         state_d = RELEASE;
                  else if (expire)   state_d = RESPOND;
         RELEASE:                    state_d = RESPOND;
         RESPOND: if (rsp_ready)     state_d = IDLE;
         default:                    state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lat_write <= 1'b0;
         lat_id    <= '0;
         lat_wdata <= '0;
         cnt       <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         wait_q    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  lat_write <= cmd_write;
                  lat_id    <= cmd_id;
                  lat_wdata <= cmd_wdata;
                  cnt       <= '0;
               end
            end
            ACQUIRE: begin
               // Grant takes priority over a timeout expiring in the same cycle.
               if (grant) begin
                  rdata_q <= lat_write ? '0 : rdata;
                  err_q   <= 1'b0;
                  wait_q  <= cnt;
               end else if (expire) begin
                  rdata_q <= '0;
                  err_q   <= 1'b1;
                  wait_q  <= TMO_VAL;
               end else if (cnt != '1) begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs decode from the state register and latched command only.
   assign cmd_ready    = (state == IDLE);
   assign req_read     = (state == ACQUIRE) && !lat_write;
   assign req_write    = (state == ACQUIRE) && lat_write;
   assign req_issue_id = (state == ACQUIRE || state == RELEASE) ? lat_id : '0;
   assign wdata        = (state == ACQUIRE) ? lat_wdata : '0;
   assign release_lock = (state == RELEASE);
   assign rsp_valid    = (state == RESPOND);
   assign rsp_rdata    = rdata_q;
   assign rsp_err      = err_q;
   assign rsp_wait     = wait_q;

endmodule

// File: tb/tb_reg_lock_access_agent.sv
// Directed bench for reg_lock_access_agent with hand-computed expectations.
module tb_reg_lock_access_agent;

   localparam int unsigned IDW = 4;
   localparam int unsigned TMO = 15;
   localparam int unsigned WW  = $clog2(TMO + 2);

   logic            clk = 1'b0;
   logic            rst_n;
   logic            cmd_valid, cmd_ready, cmd_write;
   logic [IDW-1:0]  cmd_id;
   logic [31:0]     cmd_wdata;
   logic            rsp_valid, rsp_ready, rsp_err;
   logic [31:0]     rsp_rdata;
   logic [WW-1:0]   rsp_wait;
   logic            req_read, req_write, release_lock, grant;
   logic [IDW-1:0]  req_issue_id;
   logic [31:0]     wdata, rdata;

   int tests = 0;
   int fails = 0;

   reg_lock_access_agent #(.ID_WIDTH(IDW), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_id(cmd_id), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_wait(rsp_wait),
      .req_read(req_read), .req_write(req_write), .req_issue_id(req_issue_id),
      .release_lock(release_lock), .wdata(wdata),
      .grant(grant), .rdata(rdata)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic accept(input logic wr, input logic [IDW-1:0] id, input logic [31:0] wd);
      cmd_valid = 1'b1; cmd_write = wr; cmd_id = id; cmd_wdata = wd;
      tick;
      cmd_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_id = '0; cmd_wdata = '0;
      rsp_ready = 1'b0; grant = 1'b0; rdata = '0;
      tick; tick;
      rst_n = 1'b1;
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_req_read", req_read, 0);
      check("rst_req_write", req_write, 0);
      check("rst_release", release_lock, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      check("rst_rsp_wait", rsp_wait, 0);
      check("rst_rsp_err", rsp_err, 0);

      // Read with flash grant
      accept(1'b0, 4'd3, 32'h0);
      check("flash_req_read", req_read, 1);
      check("flash_req_write", req_write, 0);
      check("flash_id", req_issue_id, 3);
      check("flash_cmd_ready", cmd_ready, 0);
      grant = 1'b1; rdata = 32'hDEADBEEF;
      tick;
      grant = 1'b0; rdata = 32'h0;
      check("flash_release", release_lock, 1);
      check("flash_req_read_off", req_read, 0);
      check("flash_rel_id", req_issue_id, 3);
      tick;
      check("flash_release_off", release_lock, 0);
      check("flash_rsp_valid", rsp_valid, 1);
      check("flash_rdata", rsp_rdata, 32'hDEADBEEF);
      check("flash_err", rsp_err, 0);
      check("flash_wait", rsp_wait, 0);
      rsp_ready = 1'b1;
      tick;
      rsp_ready = 1'b0;
      check("flash_back_idle", cmd_ready, 1);
      check("flash_rsp_drop", rsp_valid, 0);

      // Write with grant after 4 cycles; cmd_valid noise while busy
      accept(1'b1, 4'd5, 32'h12345678);
      for (int i = 0; i < 5; i++) begin
         cmd_valid = 1'b1; cmd_id = 4'd9; cmd_wdata = 32'hFFFF0000; cmd_write = 1'b0;
         check("wr_req_write", req_write, 1);
         check("wr_req_read", req_read, 0);
         check("wr_wdata", wdata, 32'h12345678);
         check("wr_id", req_issue_id, 5);
         if (i == 4) begin grant = 1'b1; rdata = 32'hAAAA5555; end
         tick;
      end
      grant = 1'b0;
      check("wr_release", release_lock, 1);
      check("wr_req_write_off", req_write, 0);
      tick;
      check("wr_rsp_valid", rsp_valid, 1);
      check("wr_rdata_zero", rsp_rdata, 0);
      check("wr_wait", rsp_wait, 4);
      check("wr_err", rsp_err, 0);
      for (int i = 0; i < 6; i++) begin
         cmd_valid = (i % 2 == 0);
         tick;
         check("bp_rsp_valid", rsp_valid, 1);
         check("bp_cmd_ready", cmd_ready, 0);
         check("bp_wait", rsp_wait, 4);
         check("bp_release", release_lock, 0);
      end
      cmd_valid = 1'b0; rsp_ready = 1'b1;
      tick;
      rsp_ready = 1'b0;
      check("bp_cmd_ready_after", cmd_ready, 1);
      tick;
      check("bp_no_stray_cmd", cmd_ready, 1);
      check("bp_no_stray_req", req_read, 0);

      // Grant on the 15th ACQUIRE cycle beats the timeout
      accept(1'b0, 4'd2, 32'h0);
      for (int i = 0; i < 15; i++) begin
         check("bnd_req_read", req_read, 1);
         if (i == 14) begin grant = 1'b1; rdata = 32'hCAFEF00D; end
         tick;
      end
      grant = 1'b0;
      check("bnd_release", release_lock, 1);
      tick;
      check("bnd_rsp_valid", rsp_valid, 1);
      check("bnd_err", rsp_err, 0);
      check("bnd_wait", rsp_wait, 14);
      check("bnd_rdata", rsp_rdata, 32'hCAFEF00D);
      rsp_ready = 1'b1;
      tick;
      rsp_ready = 1'b0;
      check("bnd_idle", cmd_ready, 1);

      // Timeout: grant never comes, rdata noise must not be captured
      rdata = 32'h13579BDF;
      accept(1'b0, 4'd7, 32'h0);
      for (int i = 0; i < 15; i++) begin
         check("tmo_req_read", req_read, 1);
         check("tmo_no_release", release_lock, 0);
         check("tmo_no_rsp", rsp_valid, 0);
         tick;
      end
      check("tmo_release_never", release_lock, 0);
      check("tmo_rsp_valid", rsp_valid, 1);
      check("tmo_err", rsp_err, 1);
      check("tmo_wait", rsp_wait, 15);
      check("tmo_rdata", rsp_rdata, 0);
      check("tmo_req_off", req_read, 0);
      rsp_ready = 1'b1;
      tick;
      rsp_ready = 1'b0;
      check("tmo_idle", cmd_ready, 1);

      // Reset in the middle of ACQUIRE
      accept(1'b1, 4'd4, 32'h0F0F0F0F);
      tick;
      check("rstm_req_write", req_write, 1);
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      check("rstm_cmd_ready", cmd_ready, 1);
      check("rstm_req_write", req_write, 0);
      check("rstm_req_read", req_read, 0);
      check("rstm_rsp_valid", rsp_valid, 0);
      check("rstm_release", release_lock, 0);
      check("rstm_err_cleared", rsp_err, 0);
      accept(1'b0, 4'd6, 32'h0);
      check("post_id", req_issue_id, 6);
      check("post_req_read", req_read, 1);
      tick;
      grant = 1'b1; rdata = 32'h0BADF00D;
      tick;
      grant = 1'b0; rdata = 32'h0;
      check("post_release", release_lock, 1);
      tick;
      check("post_rsp_valid", rsp_valid, 1);
      check("post_rdata", rsp_rdata, 32'h0BADF00D);
      check("post_wait", rsp_wait, 1);
      check("post_err", rsp_err, 0);
      rsp_ready = 1'b1;
      tick;
      rsp_ready = 1'b0;
      check("post_idle", cmd_ready, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
